// File: rtl/serial_frame_rx_if.sv
// Frame handshake bundle between serial_frame_rx and its consumer.
// master: drives frame/frame_valid, samples frame_ready; slave mirrors.
interface serial_frame_rx_if #(
  parameter int FRAME_BITS = 192
);
  logic [FRAME_BITS-1:0] frame;
  logic                  frame_valid;
  logic                  frame_ready;

  modport master (
    output frame,
    output frame_valid,
    input  frame_ready
  );

  modport slave (
    input  frame,
    input  frame_valid,
    output frame_ready
  );
endinterface

// File: rtl/serial_frame_rx.sv
// Serial frame receiver: syncs serial_clock/serial_data, hunts for a
// preamble, captures FRAME_BITS bits and holds them on out_if until
// frame_ready. Ports: clock, reset (sync, active-high), serial_data,
// serial_clock, out_if (frame/frame_valid/frame_ready), bit_count,
// busy, overrun (sticky), timeout_err (pulse).
// Optional macro SERIAL_FRAME_RX_TIMEOUT_EN adds the RECEIVE idle timeout.
module serial_frame_rx #(
  parameter int FRAME_BITS     = 192,
  parameter int PREAMBLE_BITS  = 32,
  parameter logic [PREAMBLE_BITS-1:0] PREAMBLE =
    PREAMBLE_BITS'(32'hAAAA_AAAA),
  parameter int TIMEOUT_CYCLES = 4096,
  localparam int CW = $clog2(FRAME_BITS + 1)
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         serial_data,
  input  logic         serial_clock,
  serial_frame_rx_if.master out_if,
  output logic [CW-1:0] bit_count,
  output logic         busy,
  output logic         overrun,
  output logic         timeout_err
);

  if (FRAME_BITS < 2 || FRAME_BITS > 1024) begin : g_chk_fb
    $error("serial_frame_rx: FRAME_BITS out of range");
  end
  if (PREAMBLE_BITS < 1 || PREAMBLE_BITS >= FRAME_BITS) begin : g_chk_pb
    $error("serial_frame_rx: PREAMBLE_BITS out of range");
  end
  if (TIMEOUT_CYCLES < 4) begin : g_chk_to
    $error("serial_frame_rx: TIMEOUT_CYCLES out of range");
  end

  typedef enum logic [1:0] {
    HUNT,
    RECEIVE,
    HOLD
  } state_e;

  localparam logic [CW-1:0] PB_CNT = CW'(PREAMBLE_BITS);
  localparam logic [CW-1:0] FB_CNT = CW'(FRAME_BITS);

  state_e                state_q, state_d;
  logic [FRAME_BITS-1:0] frame_q, frame_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  valid_q, valid_d;
  logic                  overrun_q, overrun_d;
  // [0]=s1, [1]=s2, [2]=s3 (clock path only)
  logic [2:0]            sclk_q, sclk_d;
  logic [1:0]            sdat_q, sdat_d;

  logic                  bit_event;
  logic                  bit_in;
  logic [FRAME_BITS-1:0] shifted;

`ifdef SERIAL_FRAME_RX_TIMEOUT_EN
  localparam int IW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IW-1:0] TO_CNT = IW'(TIMEOUT_CYCLES);
  logic [IW-1:0] idle_q, idle_d;
  logic          tmo_q, tmo_d;
`endif

  assign sclk_d    = {sclk_q[1:0], serial_clock};
  assign sdat_d    = {sdat_q[0], serial_data};
  // Rising edge seen on the synchronised clock; one event per rise.
  assign bit_event = sclk_q[1] & ~sclk_q[2];
  assign bit_in    = sdat_q[1];
  assign shifted   = {frame_q[FRAME_BITS-2:0], bit_in};

  always_comb begin
    state_d   = state_q;
    frame_d   = frame_q;
    count_d   = count_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
`ifdef SERIAL_FRAME_RX_TIMEOUT_EN
    idle_d    = '0;
    tmo_d     = 1'b0;
`endif
    unique case (state_q)
      HUNT: begin
        if (bit_event) begin
          frame_d = shifted;
          // Saturate so the window keeps sliding at full width.
          if (count_q != PB_CNT) begin
            count_d = count_q + CW'(1);
          end
          if (count_d == PB_CNT &&
              shifted[PREAMBLE_BITS-1:0] == PREAMBLE) begin
            state_d = RECEIVE;
          end
        end
      end
      RECEIVE: begin
`ifdef SERIAL_FRAME_RX_TIMEOUT_EN
        // Timeout beats a coincident bit event.
        if (idle_q == TO_CNT) begin
          state_d = HUNT;
          frame_d = '0;
          count_d = '0;
          tmo_d   = 1'b1;
        end else begin
          idle_d = bit_event ? '0 : idle_q + IW'(1);
`endif
          if (bit_event) begin
            frame_d = shifted;
            count_d = count_q + CW'(1);
            if (count_d == FB_CNT) begin
              state_d = HOLD;
              valid_d = 1'b1;
            end
          end
`ifdef SERIAL_FRAME_RX_TIMEOUT_EN
        end
`endif
      end
      HOLD: begin
        if (bit_event) begin
          overrun_d = 1'b1;
        end
        if (valid_q && out_if.frame_ready) begin
          state_d = HUNT;
          frame_d = '0;
          count_d = '0;
          valid_d = 1'b0;
        end
      end
      default: begin
        state_d = HUNT;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= HUNT;
      frame_q   <= '0;
      count_q   <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      sclk_q    <= '0;
      sdat_q    <= '0;
    end else begin
      state_q   <= state_d;
      frame_q   <= frame_d;
      count_q   <= count_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      sclk_q    <= sclk_d;
      sdat_q    <= sdat_d;
    end
  end

`ifdef SERIAL_FRAME_RX_TIMEOUT_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      idle_q <= '0;
      tmo_q  <= 1'b0;
    end else begin
      idle_q <= idle_d;
      tmo_q  <= tmo_d;
    end
  end

  assign timeout_err = tmo_q;
`else
  assign timeout_err = 1'b0;
`endif

  assign out_if.frame       = frame_q;
  assign out_if.frame_valid = valid_q;
  assign bit_count          = count_q;
  assign busy               = (state_q == RECEIVE);
  assign overrun            = overrun_q;

endmodule
